// File: rtl/rng_delay.sv
// Random-delay generator: on a rising rng_resume, waits MIN_MS + LFSR[RANGE_BITS-1:0] ms, then raises rnd_ready.
// Define RNG_FAST_SIM_EN to bypass the ms prescaler (every WAIT cycle is a tick).
module rng_delay #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned MIN_MS      = 1000,
  parameter int unsigned RANGE_BITS  = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rng_resume,
  output logic        rnd_ready,
  output logic        busy,
  output logic [15:0] delay_ms,
  output logic [15:0] lfsr_q
);

  localparam logic [15:0] RANGE_MASK = 16'((32'd1 << RANGE_BITS) - 32'd1);
  localparam logic [15:0] MIN_DELAY  = 16'(MIN_MS);
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_READY
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_resume_q;
  logic        w_req;
  logic        w_tick;
  logic [15:0] r_lfsr;
  logic [15:0] r_rem;
  logic [15:0] r_delay;
  logic [15:0] w_pick;
  logic        r_ready;
  logic        r_busy;

  assign w_req  = rng_resume & ~r_resume_q;
  assign w_pick = MIN_DELAY + (r_lfsr & RANGE_MASK);

  // Free-running in every state so the user's button timing randomises the pick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr     <= LFSR_SEED;
      r_resume_q <= 1'b0;
    end else begin
      r_lfsr     <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
      r_resume_q <= rng_resume;
    end
  end

`ifdef RNG_FAST_SIM_EN
  assign w_tick = 1'b1;
`else
  localparam int unsigned TICK_DIV = CLK_FREQ_HZ / 1000;
  localparam int unsigned PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRESC_W-1:0] r_presc;

  assign w_tick = (r_presc == PRESC_W'(TICK_DIV - 1));

  // Cleared in LOAD so the first tick lands exactly TICK_DIV cycles into WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (r_state == S_LOAD) begin
      r_presc <= '0;
    end else if (r_state == S_WAIT) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_WAIT;
      S_WAIT:  if (w_tick && (r_rem == 16'd1)) w_state_nxt = S_READY;
      S_READY: if (w_req) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rem   <= '0;
      r_delay <= '0;
    end else if (r_state == S_LOAD) begin
      r_rem   <= w_pick;
      r_delay <= w_pick;
    end else if ((r_state == S_WAIT) && w_tick) begin
      r_rem   <= r_rem - 16'd1;
    end
  end

  // Outputs registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_busy  <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_WAIT);
      r_ready <= (w_state_nxt == S_READY);
    end
  end

  assign rnd_ready = r_ready;
  assign busy      = r_busy;
  assign delay_ms  = r_delay;
  assign lfsr_q    = r_lfsr;

endmodule
